// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode map and the mul/div sequencer state encoding.
package alu_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShra = 5'b01000;
  localparam logic [4:0] OpShl  = 5'b01001;
  localparam logic [4:0] OpRor  = 5'b01010;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module twos_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = neg ? (~a + WIDTH'(1)) : a;
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide, 32 steps per operation,
// with results held in HI/LO registers and a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int unsigned WIDTH  = alu_pkg::WIDTH,
  parameter logic [4:0]  MUL_OP = alu_pkg::OpMul,
  parameter logic [4:0]  DIV_OP = alu_pkg::OpDiv
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Zhighout,
  output logic [WIDTH-1:0] Zlowout
);

  import alu_pkg::*;

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // acc holds the Booth accumulator for MUL and the partial remainder for DIV.
  logic [WIDTH:0]   acc_q, acc_d;
  // opa: multiplicand M or divisor magnitude. opq: multiplier Q or dividend/quotient.
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opq_q, opq_d;
  logic             q_m1_q, q_m1_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_q_q, sign_q_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] zhi_q, zhi_d;
  logic [WIDTH-1:0] zlo_q, zlo_d;

  logic [WIDTH-1:0] abs_a, abs_b, quot_fix, rem_fix;
  logic [WIDTH:0]   m_ext, booth_sum;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;

  twos_neg #(.WIDTH(WIDTH)) u_abs_a (.a(A), .neg(A[WIDTH-1]), .y(abs_a));
  twos_neg #(.WIDTH(WIDTH)) u_abs_b (.a(B), .neg(B[WIDTH-1]), .y(abs_b));
  twos_neg #(.WIDTH(WIDTH)) u_fix_q (.a(opq_q), .neg(sign_q_q), .y(quot_fix));
  twos_neg #(.WIDTH(WIDTH)) u_fix_r (.a(acc_q[WIDTH-1:0]), .neg(sign_a_q), .y(rem_fix));

  always_comb begin
    m_ext = {opa_q[WIDTH-1], opa_q};
    unique case ({opq_q[0], q_m1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    // Remainder stays below the divisor magnitude, so the shifted value fits WIDTH bits unsigned.
    rem_sh = {acc_q[WIDTH-2:0], opq_q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {1'b0, opa_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opq_d    = opq_q;
    q_m1_d   = q_m1_q;
    sign_a_d = sign_a_q;
    sign_q_d = sign_q_q;
    dbz_d    = dbz_q;
    zhi_d    = zhi_q;
    zlo_d    = zlo_q;

    unique case (state_q)
      StIdle: begin
        if (start && opcode == MUL_OP) begin
          opa_d   = A;
          opq_d   = B;
          acc_d   = '0;
          q_m1_d  = 1'b0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = StMul;
        end else if (start && opcode == DIV_OP) begin
          if (B != '0) begin
            opa_d    = abs_b;
            opq_d    = abs_a;
            acc_d    = '0;
            sign_a_d = A[WIDTH-1];
            sign_q_d = A[WIDTH-1] ^ B[WIDTH-1];
            cnt_d    = '0;
            dbz_d    = 1'b0;
            state_d  = StDiv;
          end else begin
            zlo_d   = '1;
            zhi_d   = A;
            dbz_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StMul: begin
        if (cnt_q == LastCnt) begin
          zhi_d   = acc_q[WIDTH-1:0];
          zlo_d   = opq_q;
          state_d = StDone;
        end else begin
          acc_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          opq_d  = {booth_sum[0], opq_q[WIDTH-1:1]};
          q_m1_d = opq_q[0];
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end else begin
          acc_d = {1'b0, (trial[WIDTH] ? rem_sh : trial[WIDTH-1:0])};
          opq_d = {opq_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFix: begin
        zlo_d   = quot_fix;
        zhi_d   = rem_fix;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opq_q    <= '0;
      q_m1_q   <= 1'b0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      dbz_q    <= 1'b0;
      zhi_q    <= '0;
      zlo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opq_q    <= opq_d;
      q_m1_q   <= q_m1_d;
      sign_a_q <= sign_a_d;
      sign_q_q <= sign_q_d;
      dbz_q    <= dbz_d;
      zhi_q    <= zhi_d;
      zlo_q    <= zlo_d;
    end
  end

  always_comb begin
    busy        = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    done        = (state_q == StDone);
    div_by_zero = dbz_q;
    Zhighout    = zhi_q;
    Zlowout     = zlo_q;
  end

endmodule
